data_hazard_scoreboard: RTL
===========================

DATA_HAZARD_SCOREBOARD -- requirements
Module: data_hazard_scoreboard

Interface
REQ-001 Parameter XLEN, default 32: data width.
REQ-002 Parameter NRP, default 2: number of ID register read ports.
REQ-003 Parameter NSTG, default 3: number of forwarding stages; index 0 is youngest (EX), NSTG-1 oldest (WB).
REQ-004 Parameter CNTW, default 16: stall-counter width.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 id_raddr_i  in  NRP*5  ID read addresses; port p at bits [5p+4:5p].
REQ-009 id_re_i  in  NRP  per-port read enable.
REQ-010 stg_waddr_i  in  NSTG*5  per-stage destination register.
REQ-011 stg_we_i  in  NSTG  per-stage write enable.
REQ-012 stg_wvalid_i  in  NSTG  per-stage write data is available; 0 for a load still in flight.
REQ-013 stg_wdata_i  in  NSTG*XLEN  per-stage write data.
REQ-014 lli_issue_i  in  1  long-latency op (div/mul) accepted this cycle.
REQ-015 lli_waddr_i  in  5  destination of the issuing long-latency op.
REQ-016 lli_done_i  in  1  a long-latency result is written back this cycle.
REQ-017 lli_done_waddr_i  in  5  destination of the completing op.
REQ-018 lli_done_wdata_i  in  XLEN  result of the completing op.
REQ-019 flush_i  in  1  pipeline flush; long-latency unit aborts in the same cycle.
REQ-020 cnt_clr_i  in  1  synchronous clear of the stall counter.
REQ-021 fwd_sel_o  out  NRP  per-port forwarded-value select.
REQ-022 fwd_data_o  out  NRP*XLEN  per-port forwarded value.
REQ-023 stall_o  out  1  hold IF/ID; insert bubble into EX.
REQ-024 sb_pending_o  out  32  scoreboard state.
REQ-025 stall_cnt_o  out  CNTW  saturating count of stalled cycles.

Function
REQ-026 A port p is live when id_re_i[p]=1 and its address is not x0; a non-live port has fwd_sel_o=0 and fwd_data_o=0, and does not stall.
REQ-027 For a live port, the sources are searched in priority order: stage 0 through NSTG-1 (match: we=1 and waddr equal), then lli_done (lli_done_i=1 and address equal), then scoreboard.
REQ-028 If the first matching source is a stage with wvalid=1, fwd_sel_o[p]=1 and fwd_data_o carries that stage's wdata.
REQ-029 If the first matching source is a stage with wvalid=0, the port stalls and fwd_sel_o[p]=0.
REQ-030 If the first match is lli_done, fwd_sel_o[p]=1 and fwd_data_o carries lli_done_wdata_i.
REQ-031 If there is no stage or lli_done match and sb_pending[addr]=1, the port stalls.
REQ-032 stall_o is the OR of all per-port stalls; forwarding and stall are combinational (0-cycle latency).
REQ-033 Scoreboard next state is pending & ~clr | set:
- set = onehot(lli_waddr_i) when lli_issue_i=1, stall_o=0 and waddr is not x0.
- clr = onehot(lli_done_waddr_i) when lli_done_i=1.
REQ-034 On a simultaneous set and clear of the same register, set wins and the bit stays 1.
REQ-035 flush_i=1 clears all scoreboard bits next cycle and overrides set and clear.
REQ-036 When stall_o=1, stall_cnt_o increments by 1 and saturates at all-ones.
REQ-037 cnt_clr_i=1 zeroes stall_cnt_o next cycle and takes precedence over an increment.

Reset
REQ-038 Reset drives sb_pending_o=0 and stall_cnt_o=0 immediately; combinational outputs follow from zero state.
REQ-039 Reset asserted mid-operation discards all pending bits; a later lli_done_i for a discarded op only clears an already-zero bit.

Structure
REQ-040 A shared package holds REG_AW=5, NREGS=32, and the default XLEN, NRP, NSTG and CNTW.
REQ-041 The per-port priority search lives in one sub-module, dhs_port_resolve, instantiated NRP times; the scoreboard and counter live at the top level.

Verification
REQ-042 Stage1 writes x5=0x11, stage2 writes x5=0x22, port0 reads x5 -> fwd_sel_o[0]=1 and data 0x11.
REQ-043 Stage0 has a load to x7 with wvalid=0 and port1 reads x7 -> stall_o=1 and stall_cnt_o=1 next cycle; when wvalid=1 -> data is forwarded and stall_o=0.
REQ-044 Issue div to x9; three cycles later port0 reads x9 -> stall_o=1 while pending; the cycle lli_done_i=1 with 0xDEAD -> fwd data 0xDEAD, stall_o=0, and sb_pending_o[9]=0 next cycle.
REQ-045 lli_issue_i and lli_done_i both target x3 in the same cycle -> sb_pending_o[3] remains 1.
REQ-046 Reads of x0 with all stages writing x0 -> fwd_sel_o=0 and stall_o=0; with CNTW=4, force 20 stall cycles -> stall_cnt_o=0xF.
REQ-047 Pending bits for x4 and x8, then flush_i -> sb_pending_o=0 next cycle; reset asserted mid-stall -> all state 0 asynchronously.

Source files
------------

// File: rtl/data_hazard_scoreboard_pkg.sv
// data_hazard_scoreboard_pkg: shared constants and parameter defaults for the hazard scoreboard.
package data_hazard_scoreboard_pkg;
  localparam int REG_AW    = 5;
  localparam int NREGS     = 32;
  localparam int DEF_XLEN  = 32;
  localparam int DEF_NRP   = 2;
  localparam int DEF_NSTG  = 3;
  localparam int DEF_CNTW  = 16;
endpackage

// File: rtl/data_hazard_scoreboard_port_resolve.sv
// dhs_port_resolve: per-read-port priority search over stages, long-latency writeback and scoreboard.
module dhs_port_resolve
  import data_hazard_scoreboard_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NSTG = DEF_NSTG
) (
  input  logic [REG_AW-1:0]      raddr,
  input  logic                   re,
  input  logic [NSTG*REG_AW-1:0] stg_waddr,
  input  logic [NSTG-1:0]        stg_we,
  input  logic [NSTG-1:0]        stg_wvalid,
  input  logic [NSTG*XLEN-1:0]   stg_wdata,
  input  logic                   lli_done,
  input  logic [REG_AW-1:0]      lli_done_waddr,
  input  logic [XLEN-1:0]        lli_done_wdata,
  input  logic [NREGS-1:0]       pending,
  output logic                   sel,
  output logic [XLEN-1:0]        data,
  output logic                   stall
);
  logic live;
  logic hit;
  assign live = re && raddr != '0;
  // Youngest matching source wins; a stage match without data blocks older sources.
  always_comb begin
    hit   = 1'b0;
    sel   = 1'b0;
    data  = '0;
    stall = 1'b0;
    for (int i = 0; i < NSTG; i++)
      if (!hit && live && stg_we[i] && stg_waddr[i*REG_AW +: REG_AW] == raddr) begin
        hit   = 1'b1;
        sel   = stg_wvalid[i];
        stall = !stg_wvalid[i];
        data  = stg_wvalid[i] ? stg_wdata[i*XLEN +: XLEN] : '0;
      end
    if (!hit && live && lli_done && lli_done_waddr == raddr) begin
      hit  = 1'b1;
      sel  = 1'b1;
      data = lli_done_wdata;
    end
    if (!hit && live && pending[raddr]) stall = 1'b1;
  end
endmodule

// File: rtl/data_hazard_scoreboard.sv
// data_hazard_scoreboard: operand forwarding, stall generation, long-latency scoreboard and stall counter.
module data_hazard_scoreboard
  import data_hazard_scoreboard_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NRP  = DEF_NRP,
  parameter int NSTG = DEF_NSTG,
  parameter int CNTW = DEF_CNTW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRP*REG_AW-1:0]  id_raddr_i,
  input  logic [NRP-1:0]         id_re_i,
  input  logic [NSTG*REG_AW-1:0] stg_waddr_i,
  input  logic [NSTG-1:0]        stg_we_i,
  input  logic [NSTG-1:0]        stg_wvalid_i,
  input  logic [NSTG*XLEN-1:0]   stg_wdata_i,
  input  logic                   lli_issue_i,
  input  logic [REG_AW-1:0]      lli_waddr_i,
  input  logic                   lli_done_i,
  input  logic [REG_AW-1:0]      lli_done_waddr_i,
  input  logic [XLEN-1:0]        lli_done_wdata_i,
  input  logic                   flush_i,
  input  logic                   cnt_clr_i,
  output logic [NRP-1:0]         fwd_sel_o,
  output logic [NRP*XLEN-1:0]    fwd_data_o,
  output logic                   stall_o,
  output logic [NREGS-1:0]       sb_pending_o,
  output logic [CNTW-1:0]        stall_cnt_o
);
  logic [NRP-1:0]   port_stall;
  logic [NREGS-1:0] set_v, clr_v;
  for (genvar p = 0; p < NRP; p++) begin : g_port
    dhs_port_resolve #(.XLEN(XLEN), .NSTG(NSTG)) u_res (
      .raddr          (id_raddr_i[p*REG_AW +: REG_AW]),
      .re             (id_re_i[p]),
      .stg_waddr      (stg_waddr_i),
      .stg_we         (stg_we_i),
      .stg_wvalid     (stg_wvalid_i),
      .stg_wdata      (stg_wdata_i),
      .lli_done       (lli_done_i),
      .lli_done_waddr (lli_done_waddr_i),
      .lli_done_wdata (lli_done_wdata_i),
      .pending        (sb_pending_o),
      .sel            (fwd_sel_o[p]),
      .data           (fwd_data_o[p*XLEN +: XLEN]),
      .stall          (port_stall[p])
    );
  end
  assign stall_o = |port_stall;
  // A stalled issue is not accepted, so it must not mark its destination.
  assign set_v = (lli_issue_i && !stall_o && lli_waddr_i != '0) ? NREGS'(1) << lli_waddr_i : '0;
  assign clr_v = lli_done_i ? NREGS'(1) << lli_done_waddr_i : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) sb_pending_o <= '0;
    else if (flush_i) sb_pending_o <= '0;
    else sb_pending_o <= (sb_pending_o & ~clr_v) | set_v;
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt_o <= '0;
    else if (cnt_clr_i) stall_cnt_o <= '0;
    else if (stall_o && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + CNTW'(1);
endmodule
